// File: rtl/adder_tree_pkg.sv
// Shared width rules for reduction trees: log2, level count, output width,
// and the one-bit sign/zero extension applied before every add.
package adder_tree_pkg;

    function automatic int clog2(input int value);
        int result;
        result = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < value) result = i + 1;
        end
        return result;
    endfunction

    function automatic int tree_levels(input int n_inputs);
        return clog2(n_inputs);
    endfunction

    function automatic int tree_out_width(input int in_width, input int n_inputs);
        return in_width + clog2(n_inputs);
    endfunction

    // Bit prepended to an operand's MSB side to widen it by one position.
    function automatic logic ext_bit(input logic msb, input bit is_signed);
        return is_signed ? msb : 1'b0;
    endfunction

endpackage

// File: rtl/adder_tree_level.sv
// One registered level of the tree: adds PAIRS adjacent operand pairs, each
// widened by one bit first, and registers the sums with a travelling valid.
module adder_tree_level
    import adder_tree_pkg::*;
#(
    parameter int PAIRS    = 1,
    parameter int IN_WIDTH = 8,
    parameter bit SIGNED   = 1'b0
) (
    input  logic                            clk,
    input  logic                            rst_n,
    input  logic                            en,
    input  logic [2*PAIRS*IN_WIDTH-1:0]     in_bus,
    input  logic                            in_vld,
    output logic [PAIRS*(IN_WIDTH+1)-1:0]   out_bus,
    output logic                            out_vld
);

    localparam int OUT_W = IN_WIDTH + 1;

    logic [PAIRS*OUT_W-1:0] sum_bus;

    function automatic logic [OUT_W-1:0] widen(input logic [IN_WIDTH-1:0] v);
        return {ext_bit(v[IN_WIDTH-1], SIGNED), v};
    endfunction

    always_comb begin
        // NOTE: default assignment first so no path through the block leaves sum_bus unassigned (no latch).
        sum_bus = '0;
        for (int p = 0; p < PAIRS; p++) begin
            sum_bus[p*OUT_W +: OUT_W] = widen(in_bus[(2*p)*IN_WIDTH +: IN_WIDTH])
                                      + widen(in_bus[(2*p+1)*IN_WIDTH +: IN_WIDTH]);
        end
    end

    // NOTE: data registers are reset too, so out_sum reads 0 out of reset rather than stale contents.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            // NOTE: non-blocking assignments so every level samples the previous level's old value.
            out_bus <= '0;
            out_vld <= 1'b0;
        end else if (en) begin
            out_bus <= sum_bus;
            out_vld <= in_vld;
        end
    end

endmodule

// File: rtl/pipelined_adder_tree.sv
// Pipelined binary adder tree, one register per level, with a single global
// advance enable so the whole pipeline stalls together under backpressure.
module pipelined_adder_tree
    import adder_tree_pkg::*;
#(
    parameter int N_INPUTS  = 4,
    parameter int IN_WIDTH  = 8,
    parameter int SIGNED    = 0,
    localparam int LEVELS    = tree_levels(N_INPUTS),
    localparam int OUT_WIDTH = tree_out_width(IN_WIDTH, N_INPUTS)
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic [N_INPUTS*IN_WIDTH-1:0] in_data,
    input  logic                         in_valid,
    output logic                         in_ready,
    output logic [OUT_WIDTH-1:0]         out_sum,
    output logic                         out_valid,
    input  logic                         out_ready
);

    logic adv;

    // Stage 0 is the raw input; stage k is the output of level k.
    for (genvar k = 0; k <= LEVELS; k++) begin : g_stage
        logic [(N_INPUTS >> k)*(IN_WIDTH + k)-1:0] bus;
        logic                                      vld;

        if (k == 0) begin : g_src
            assign bus = in_data;
            assign vld = in_valid;
        end else begin : g_lvl
            adder_tree_level #(
                .PAIRS    (N_INPUTS >> k),
                .IN_WIDTH (IN_WIDTH + k - 1),
                .SIGNED   (SIGNED != 0)
            ) u_level (
                .clk     (clk),
                .rst_n   (rst_n),
                .en      (adv),
                .in_bus  (g_stage[k-1].bus),
                .in_vld  (g_stage[k-1].vld),
                .out_bus (bus),
                .out_vld (vld)
            );
        end
    end

    assign out_sum   = g_stage[LEVELS].bus;
    assign out_valid = g_stage[LEVELS].vld;
    assign adv       = !out_valid || out_ready;
    assign in_ready  = adv;

endmodule

// File: tb/tb_pipelined_adder_tree.sv
// Directed bench for pipelined_adder_tree: unsigned 4x8, signed 4x8 and
// unsigned 8x4 instances, table-driven single shots plus multi-cycle sequences.
module tb_pipelined_adder_tree;

    logic clk;
    logic rst_n;

    logic [31:0] d_in;  logic d_iv, d_ir, d_ov, d_or;  logic [9:0] d_sum;
    logic [31:0] s_in;  logic s_iv, s_ir, s_ov, s_or;  logic [9:0] s_sum;
    logic [31:0] w_in;  logic w_iv, w_ir, w_ov, w_or;  logic [6:0] w_sum;

    int n_vec = 0;
    int n_bad = 0;

    pipelined_adder_tree #(.N_INPUTS(4), .IN_WIDTH(8), .SIGNED(0)) u_dut (
        .clk(clk), .rst_n(rst_n), .in_data(d_in), .in_valid(d_iv), .in_ready(d_ir),
        .out_sum(d_sum), .out_valid(d_ov), .out_ready(d_or));

    pipelined_adder_tree #(.N_INPUTS(4), .IN_WIDTH(8), .SIGNED(1)) u_sgn (
        .clk(clk), .rst_n(rst_n), .in_data(s_in), .in_valid(s_iv), .in_ready(s_ir),
        .out_sum(s_sum), .out_valid(s_ov), .out_ready(s_or));

    pipelined_adder_tree #(.N_INPUTS(8), .IN_WIDTH(4), .SIGNED(0)) u_wide (
        .clk(clk), .rst_n(rst_n), .in_data(w_in), .in_valid(w_iv), .in_ready(w_ir),
        .out_sum(w_sum), .out_valid(w_ov), .out_ready(w_or));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", name, act, act, exp, exp);
        end
    endtask

    // Outputs are observed 1 ns after the rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] pack4(input int a0, input int a1, input int a2, input int a3);
        return {a3[7:0], a2[7:0], a1[7:0], a0[7:0]};
    endfunction

    function automatic logic [6:0] wide_model(input logic [31:0] v);
        int s;
        s = 0;
        for (int i = 0; i < 8; i++) s += int'(v[i*4 +: 4]);
        return s[6:0];
    endfunction

    typedef struct {
        string       name;
        bit          sgn;
        logic [31:0] ops;
        logic [9:0]  exp;
    } vec_t;

    vec_t tbl[10];

    logic [31:0] s3_vec[4];
    logic [9:0]  s3_exp[4];

    initial begin
        logic [6:0] q[$];
        int i_in, n_out, stall_left, got;

        tbl[0] = '{"u_max",      1'b0, pack4(255, 255, 255, 255), 10'h3FC};
        tbl[1] = '{"u_small",    1'b0, pack4(1, 2, 3, 4),         10'd10};
        tbl[2] = '{"u_zero",     1'b0, pack4(0, 0, 0, 0),         10'd0};
        tbl[3] = '{"u_carry",    1'b0, pack4(128, 127, 1, 0),     10'd256};
        tbl[4] = '{"u_mixed",    1'b0, pack4(200, 100, 50, 25),   10'd375};
        tbl[5] = '{"s_min",      1'b1, pack4(-128, -128, -128, -128), 10'h200};
        tbl[6] = '{"s_cancel",   1'b1, pack4(127, -1, 0, -126),   10'd0};
        tbl[7] = '{"s_minus1",   1'b1, pack4(-1, -1, -1, -1),     10'h3FC};
        tbl[8] = '{"s_max",      1'b1, pack4(127, 127, 127, 127), 10'h1FC};
        tbl[9] = '{"s_mixed",    1'b1, pack4(100, -50, -100, 25), 10'h3E7};

        s3_vec[0] = pack4(0, 3, 1, 255);    s3_exp[0] = 10'd259;
        s3_vec[1] = pack4(10, 13, 9, 10);   s3_exp[1] = 10'd42;
        s3_vec[2] = pack4(15, 15, 109, 37); s3_exp[2] = 10'd176;
        s3_vec[3] = pack4(0, 9, 45, 45);    s3_exp[3] = 10'd99;

        rst_n = 1'b0;
        d_in = '0; d_iv = 1'b0; d_or = 1'b1;
        s_in = '0; s_iv = 1'b0; s_or = 1'b1;
        w_in = '0; w_iv = 1'b0; w_or = 1'b1;
        #1;
        check("reset_out_valid", {31'd0, d_ov}, 32'd0);
        check("reset_out_sum", {22'd0, d_sum}, 32'd0);
        check("reset_in_ready", {31'd0, d_ir}, 32'd1);
        check("reset_wide_valid", {31'd0, w_ov}, 32'd0);
        repeat (2) @(posedge clk);
        #4 rst_n = 1'b1;
        step();

        // Latency counted in rising edges from the accepting edge: L1 loads on
        // edge 1, the output register on edge 2 (3 for the 8-input tree).
        for (int i = 0; i < 10; i++) begin
            if (tbl[i].sgn) begin s_in = tbl[i].ops; s_iv = 1'b1; end
            else            begin d_in = tbl[i].ops; d_iv = 1'b1; end
            step();
            d_iv = 1'b0; s_iv = 1'b0; d_in = $urandom; s_in = $urandom;
            check({tbl[i].name, "_early"}, {31'd0, tbl[i].sgn ? s_ov : d_ov}, 32'd0);
            step();
            check({tbl[i].name, "_valid"}, {31'd0, tbl[i].sgn ? s_ov : d_ov}, 32'd1);
            check({tbl[i].name, "_sum"}, {22'd0, tbl[i].sgn ? s_sum : d_sum}, {22'd0, tbl[i].exp});
            step();
            check({tbl[i].name, "_single"}, {31'd0, tbl[i].sgn ? s_ov : d_ov}, 32'd0);
        end

        // Back-to-back stream: results on four consecutive cycles, in order.
        for (int c = 0; c < 7; c++) begin
            d_iv = (c < 4);
            d_in = (c < 4) ? s3_vec[c] : $urandom;
            step();
            check($sformatf("stream_valid_c%0d", c), {31'd0, d_ov}, {31'd0, (c >= 1 && c <= 4)});
            if (c >= 1 && c <= 4)
                check($sformatf("stream_sum_%0d", c - 1), {22'd0, d_sum}, {22'd0, s3_exp[c-1]});
        end

        // Backpressure: stall 3 cycles once the first result is valid, with
        // garbage offered upstream while in_ready is low.
        i_in = 0; n_out = 0; stall_left = -1;
        for (int cyc = 0; cyc < 30 && n_out < 4; cyc++) begin
            if (stall_left < 0 && d_ov) stall_left = 3;
            d_or = !(stall_left > 0);
            if (stall_left > 0) begin
                d_iv = stall_left[0];
                d_in = $urandom;
            end else begin
                d_iv = (i_in < 4);
                d_in = (i_in < 4) ? s3_vec[i_in] : '0;
            end
            #1;
            if (stall_left > 0) begin
                check($sformatf("stall_in_ready_%0d", stall_left), {31'd0, d_ir}, 32'd0);
                check($sformatf("stall_out_valid_%0d", stall_left), {31'd0, d_ov}, 32'd1);
                check($sformatf("stall_out_sum_%0d", stall_left), {22'd0, d_sum}, 32'd259);
                stall_left--;
            end
            if (d_iv && d_ir) i_in++;
            if (d_ov && d_or) begin
                check($sformatf("bp_sum_%0d", n_out), {22'd0, d_sum}, {22'd0, s3_exp[n_out]});
                n_out++;
            end
            step();
        end
        check("bp_outputs", n_out, 32'd4);
        check("bp_inputs", i_in, 32'd4);
        d_iv = 1'b0; d_or = 1'b1;
        for (int c = 0; c < 3; c++) begin
            step();
            check($sformatf("bp_no_dup_%0d", c), {31'd0, d_ov}, 32'd0);
        end

        // Reset with two vectors in flight, then a clean vector afterwards.
        d_iv = 1'b1; d_in = pack4(1, 1, 1, 1);
        step();
        d_in = pack4(2, 2, 2, 2);
        step();
        d_iv = 1'b0;
        check("pre_reset_valid", {31'd0, d_ov}, 32'd1);
        rst_n = 1'b0;
        #1;
        check("rst_async_valid", {31'd0, d_ov}, 32'd0);
        check("rst_async_sum", {22'd0, d_sum}, 32'd0);
        check("rst_async_ready", {31'd0, d_ir}, 32'd1);
        repeat (2) @(posedge clk);
        #4 rst_n = 1'b1;
        for (int c = 0; c < 4; c++) begin
            step();
            check($sformatf("post_reset_idle_%0d", c), {31'd0, d_ov}, 32'd0);
        end
        d_iv = 1'b1; d_in = pack4(10, 20, 30, 40);
        step();
        d_iv = 1'b0;
        check("post_reset_early", {31'd0, d_ov}, 32'd0);
        step();
        check("post_reset_valid", {31'd0, d_ov}, 32'd1);
        check("post_reset_sum", {22'd0, d_sum}, 32'd100);

        // Eight 4-bit operands: three levels, 7-bit result.
        w_iv = 1'b1; w_in = 32'hFFFF_FFFF;
        step();
        w_iv = 1'b0; w_in = $urandom;
        check("wide_lat1", {31'd0, w_ov}, 32'd0);
        step();
        check("wide_lat2", {31'd0, w_ov}, 32'd0);
        step();
        check("wide_valid", {31'd0, w_ov}, 32'd1);
        check("wide_sum", {25'd0, w_sum}, 32'd120);
        step();
        check("wide_single", {31'd0, w_ov}, 32'd0);

        // Random stream with random backpressure against a queue of model sums.
        got = 0;
        for (int cyc = 0; cyc < 150; cyc++) begin
            w_iv = (cyc < 100) && ($urandom_range(0, 3) != 0);
            w_in = $urandom;
            w_or = (cyc >= 100) || ($urandom_range(0, 3) != 0);
            #1;
            if (w_iv && w_ir) q.push_back(wide_model(w_in));
            if (w_ov && w_or) begin
                if (q.size() == 0) begin
                    check("wide_unexpected_out", {31'd0, w_ov}, 32'd0);
                end else begin
                    check($sformatf("wide_rand_%0d", got), {25'd0, w_sum}, {25'd0, q.pop_front()});
                    got++;
                end
            end
            step();
        end
        check("wide_drained", q.size(), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
